// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - DMEM map, LSU state encoding, funct3 and mcause constants
package memory_pkg;

  localparam logic [31:0] MAP_DMEM_BASE   = 32'h0001_0000;
  localparam logic [31:0] DMEM_SIZE_BYTES = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store)
      return f3[2] || (f3[1:0] == 2'b11);
    else
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-enable/lane generation, request checks, load extraction
// Optional address range check enabled by LSU_RANGE_CHECK_EN.
module lsu_align
  import memory_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = MAP_DMEM_BASE,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_BYTES
) (
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic        err,
  output logic [3:0]  cause,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic        illegal;
  logic        misalign;
  logic        fault;
  logic [31:0] shifted;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    misalign   = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr[1:0];
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << {addr[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        misalign   = addr[0];
      end
      default: begin
        misalign   = (addr[1:0] != 2'b00);
      end
    endcase
  end

  assign illegal = f3_illegal(store, funct3);

`ifdef LSU_RANGE_CHECK_EN
  assign fault = (addr < DMEM_BASE) || ((addr - DMEM_BASE) >= DMEM_SIZE);
`else
  logic unused_range;
  assign unused_range = ^{DMEM_BASE, DMEM_SIZE, addr[31:2]};
  assign fault        = 1'b0;
`endif

  always_comb begin
    err   = 1'b1;
    cause = 4'd0;
    if (illegal)
      cause = CAUSE_ILLEGAL;
    else if (misalign)
      cause = store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
    else if (fault)
      cause = store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
    else
      err = 1'b0;
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit FSM driving the native DMEM interface
// Optional address range check enabled by LSU_RANGE_CHECK_EN (see lsu_align).
module lsu_ctrl
  import memory_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = MAP_DMEM_BASE,
  parameter logic [31:0] DMEM_SIZE = DMEM_SIZE_BYTES
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [3:0]  rsp_cause_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [3:0]  cause_q;

  logic [3:0]  req_be;
  logic [31:0] req_lane;
  logic        req_err;
  logic [3:0]  req_cause;
  logic [31:0] ld_data;
  logic        accept;

  lsu_align #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_SIZE (DMEM_SIZE)
  ) u_align (
    .store      (req_store_i),
    .funct3     (req_funct3_i),
    .addr       (req_addr_i),
    .wdata      (req_wdata_i),
    .be         (req_be),
    .wdata_lane (req_lane),
    .err        (req_err),
    .cause      (req_cause),
    .ld_funct3  (f3_q),
    .ld_off     (addr_q[1:0]),
    .rdata      (mem_rdata_i),
    .ld_data    (ld_data)
  );

  assign accept = (state_q == IDLE) && req_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cause_q <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q <= req_store_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        be_q    <= req_be;
        wdata_q <= req_lane;
        rdata_q <= 32'd0;
        err_q   <= req_err;
        cause_q <= req_cause;
      end
      if ((state_q == ACCESS) && !store_q)
        rdata_q <= ld_data;
    end
  end

  // mem_* decode straight from state_q so an async reset kills the strobe before the write edge.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'd0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i)
          state_d = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = store_q;
        mem_be_o    = be_q;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = wdata_q;
        state_d     = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign rsp_cause_o = cause_q;

endmodule
